// File: rtl/brisc_pipe_ctrl_pkg.sv
// Shared BRISC pipeline-control types: forwarding-select encodings and stage records.
// Register addresses are stored zero-extended to REG_AW_MAX bits, so REG_AW must not exceed it.
package brisc_pipe_ctrl_pkg;

    localparam int REG_AW_MAX = 8;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'd0;
    localparam fwd_sel_t FWD_EX  = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] c_addr;
        logic                  reg_write;
        logic                  data_read;
    } stage_rec_t;

    typedef struct packed {
        stage_rec_t            base;
        logic [REG_AW_MAX-1:0] a_addr;
        logic [REG_AW_MAX-1:0] b_addr;
        logic                  use_a;
        logic                  use_b;
    } dec_rec_t;

endpackage

// File: rtl/brisc_fwd_sel.sv
// Forwarding select for one decode-stage source operand; purely combinational.
// Execute wins over writeback; a load in execute cannot forward (its data is not ready yet).
module brisc_fwd_sel
    import brisc_pipe_ctrl_pkg::*;
(
    input  logic                  d_valid,
    input  logic                  src_use,
    input  logic [REG_AW_MAX-1:0] src_addr,
    input  logic                  e_valid,
    input  logic                  e_reg_write,
    input  logic                  e_data_read,
    input  logic [REG_AW_MAX-1:0] e_c_addr,
    input  logic                  w_valid,
    input  logic                  w_reg_write,
    input  logic [REG_AW_MAX-1:0] w_c_addr,
    output fwd_sel_t              sel
);

    logic e_hit;
    logic w_hit;

    assign e_hit = e_valid && e_reg_write && !e_data_read && (e_c_addr == src_addr);
    assign w_hit = w_valid && w_reg_write && (w_c_addr == src_addr);

    always_comb begin
        sel = FWD_REG;
        if (d_valid && src_use) begin
            if (e_hit) begin
                sel = FWD_EX;
            end else if (w_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/brisc_pipe_ctrl.sv
// BRISC D/E/W hazard control: load-use stall, jump flush, operand forwarding, event counters.
// Outputs are combinational from stage state; a load-use hazard costs one bubble, flush overrides stall.
module brisc_pipe_ctrl
    import brisc_pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              if_valid,
    input  logic [REG_AW-1:0] if_a_addr,
    input  logic [REG_AW-1:0] if_b_addr,
    input  logic [REG_AW-1:0] if_c_addr,
    input  logic              if_use_a,
    input  logic              if_use_b,
    input  logic              if_reg_write,
    input  logic              if_data_read,
    input  logic              jump_en,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              d_valid,
    output logic              e_valid,
    output logic              w_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    dec_rec_t   d_rec;
    dec_rec_t   fetch_rec;
    stage_rec_t e_rec;
    stage_rec_t w_rec;
    logic       load_use;

    always_comb begin
        fetch_rec                = '0;
        fetch_rec.base.valid     = if_valid;
        fetch_rec.base.c_addr    = REG_AW_MAX'(if_c_addr);
        fetch_rec.base.reg_write = if_reg_write;
        fetch_rec.base.data_read = if_data_read;
        fetch_rec.a_addr         = REG_AW_MAX'(if_a_addr);
        fetch_rec.b_addr         = REG_AW_MAX'(if_b_addr);
        fetch_rec.use_a          = if_use_a;
        fetch_rec.use_b          = if_use_b;
    end

    assign load_use = d_rec.base.valid && e_rec.valid && e_rec.data_read && e_rec.reg_write &&
                      ((d_rec.use_a && (d_rec.a_addr == e_rec.c_addr)) ||
                       (d_rec.use_b && (d_rec.b_addr == e_rec.c_addr)));

    assign flush   = jump_en && e_rec.valid;
    assign stall   = load_use && !flush;
    assign d_valid = d_rec.base.valid;
    assign e_valid = e_rec.valid;
    assign w_valid = w_rec.valid;

    // Writeback never feeds a hazard check on its load flag; it is kept only for record symmetry.
    logic unused_w_data_read;
    assign unused_w_data_read = w_rec.data_read;

    brisc_fwd_sel u_fwd_a (
        .d_valid     (d_rec.base.valid),
        .src_use     (d_rec.use_a),
        .src_addr    (d_rec.a_addr),
        .e_valid     (e_rec.valid),
        .e_reg_write (e_rec.reg_write),
        .e_data_read (e_rec.data_read),
        .e_c_addr    (e_rec.c_addr),
        .w_valid     (w_rec.valid),
        .w_reg_write (w_rec.reg_write),
        .w_c_addr    (w_rec.c_addr),
        .sel         (fwd_a)
    );

    brisc_fwd_sel u_fwd_b (
        .d_valid     (d_rec.base.valid),
        .src_use     (d_rec.use_b),
        .src_addr    (d_rec.b_addr),
        .e_valid     (e_rec.valid),
        .e_reg_write (e_rec.reg_write),
        .e_data_read (e_rec.data_read),
        .e_c_addr    (e_rec.c_addr),
        .w_valid     (w_rec.valid),
        .w_reg_write (w_rec.reg_write),
        .w_c_addr    (w_rec.c_addr),
        .sel         (fwd_b)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_rec <= '0;
            e_rec <= '0;
            w_rec <= '0;
        end else begin
            w_rec <= e_rec;
            if (flush) begin
                e_rec <= '0;
                d_rec <= '0;
            end else if (stall) begin
                e_rec <= '0;
            end else begin
                e_rec <= d_rec.base;
                d_rec <= fetch_rec;
            end
        end
    end

    // Counters saturate at all-ones so long runs never alias to small values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brisc_pipe_ctrl.sv
// Bench for brisc_pipe_ctrl: vector table through a scoreboard queue, then saturation and reset corner cases.
module tb_brisc_pipe_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       if_valid;
    logic [3:0] if_a_addr, if_b_addr, if_c_addr;
    logic       if_use_a, if_use_b, if_reg_write, if_data_read;
    logic       jump_en;

    logic        stall, flush, d_valid, e_valid, w_valid;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        stall_s, flush_s, d_valid_s, e_valid_s, w_valid_s;
    logic [1:0]  fwd_a_s, fwd_b_s;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    brisc_pipe_ctrl #(.REG_AW(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .if_valid(if_valid),
        .if_a_addr(if_a_addr), .if_b_addr(if_b_addr), .if_c_addr(if_c_addr),
        .if_use_a(if_use_a), .if_use_b(if_use_b), .if_reg_write(if_reg_write),
        .if_data_read(if_data_read), .jump_en(jump_en),
        .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .d_valid(d_valid), .e_valid(e_valid), .w_valid(w_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    brisc_pipe_ctrl #(.REG_AW(4), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .if_valid(if_valid),
        .if_a_addr(if_a_addr), .if_b_addr(if_b_addr), .if_c_addr(if_c_addr),
        .if_use_a(if_use_a), .if_use_b(if_use_b), .if_reg_write(if_reg_write),
        .if_data_read(if_data_read), .jump_en(jump_en),
        .stall(stall_s), .flush(flush_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
        .d_valid(d_valid_s), .e_valid(e_valid_s), .w_valid(w_valid_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       st, fl;
        logic [1:0] fa, fb;
        logic       dv, ev, wv;
        int         sc, fc;
    } exp_t;

    typedef struct {
        logic       v;
        logic [3:0] a, b, c;
        logic       ua, ub, rw, rd, j;
        exp_t       e;
    } vec_t;

    vec_t vecs[13];
    exp_t sb_q[$];

    function automatic vec_t mk(input logic v, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic ua, input logic ub,
                                input logic rw, input logic rd, input logic j,
                                input logic st, input logic fl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic dv, input logic ev,
                                input logic wv, input int sc, input int fc);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.c = c;
        r.ua = ua; r.ub = ub; r.rw = rw; r.rd = rd; r.j = j;
        r.e.st = st; r.e.fl = fl; r.e.fa = fa; r.e.fb = fb;
        r.e.dv = dv; r.e.ev = ev; r.e.wv = wv; r.e.sc = sc; r.e.fc = fc;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic ua, input logic ub,
                         input logic rw, input logic rd, input logic j);
        if_valid = v; if_a_addr = a; if_b_addr = b; if_c_addr = c;
        if_use_a = ua; if_use_b = ub; if_reg_write = rw; if_data_read = rd;
        jump_en = j;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".stall"}, stall, 0);
        check({tag, ".flush"}, flush, 0);
        check({tag, ".fwd_a"}, fwd_a, 0);
        check({tag, ".fwd_b"}, fwd_b, 0);
        check({tag, ".d_valid"}, d_valid, 0);
        check({tag, ".e_valid"}, e_valid, 0);
        check({tag, ".w_valid"}, w_valid, 0);
        check({tag, ".stall_cnt"}, stall_cnt, 0);
        check({tag, ".flush_cnt"}, flush_cnt, 0);
        check({tag, ".sat_stall_cnt"}, stall_cnt_s, 0);
        check({tag, ".sat_flush_cnt"}, flush_cnt_s, 0);
        check({tag, ".sat_valids"}, {d_valid_s, e_valid_s, w_valid_s, stall_s, flush_s}, 0);
        check({tag, ".sat_fwd"}, {fwd_a_s, fwd_b_s}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t x;

        // Reset held with a live fetch and jump request: nothing may load or fire.
        RST_N = 1'b0;
        drive(1, 4'd1, 4'd2, 4'd3, 1, 1, 1, 1, 1);
        repeat (2) @(negedge CLK);
        #2;
        check_idle("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        //             v  a  b  c  ua ub rw rd j   st fl fa fb dv ev wv sc fc
        vecs[0]  = mk(1, 2, 3, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 3, 2, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 6, 0, 4, 1, 0, 1, 1, 0,  0, 0, 1, 0, 1, 1, 0, 0, 0);
        vecs[3]  = mk(1, 8, 4, 7, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 5, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 5, 0, 0, 1, 0, 0,  0, 0, 0, 2, 1, 0, 1, 1, 0);
        vecs[6]  = mk(1, 0, 0, 5, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1, 0);
        vecs[7]  = mk(1, 5, 5, 10, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        vecs[8]  = mk(1, 0, 0, 11, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0);
        vecs[9]  = mk(1, 11, 10, 12, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        vecs[10] = mk(1, 1, 1, 1, 1, 1, 1, 0, 1,  0, 1, 0, 2, 1, 1, 1, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ua,
                  vecs[i].ub, vecs[i].rw, vecs[i].rd, vecs[i].j);
            sb_q.push_back(vecs[i].e);
            #2;
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d.scoreboard", i), 0, 1);
            end else begin
                x = sb_q.pop_front();
                check($sformatf("v%0d.stall", i), stall, x.st);
                check($sformatf("v%0d.flush", i), flush, x.fl);
                check($sformatf("v%0d.fwd_a", i), fwd_a, x.fa);
                check($sformatf("v%0d.fwd_b", i), fwd_b, x.fb);
                check($sformatf("v%0d.d_valid", i), d_valid, x.dv);
                check($sformatf("v%0d.e_valid", i), e_valid, x.ev);
                check($sformatf("v%0d.w_valid", i), w_valid, x.wv);
                check($sformatf("v%0d.stall_cnt", i), stall_cnt, x.sc);
                check($sformatf("v%0d.flush_cnt", i), flush_cnt, x.fc);
            end
            @(negedge CLK);
        end

        // Five flush events from a clean reset: wide counter counts, 2-bit counter pins at 3.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
        @(negedge CLK);
        for (int k = 1; k <= 5; k++) begin
            drive(1, 0, 0, 3, 0, 0, 1, 0, 0);
            @(negedge CLK);
            drive(1, 0, 0, 3, 0, 0, 1, 0, 0);
            @(negedge CLK);
            drive(1, 0, 0, 3, 0, 0, 1, 0, 1);
            #2;
            check($sformatf("sat%0d.flush", k), flush, 1);
            @(negedge CLK);
            check($sformatf("sat%0d.flush_cnt", k), flush_cnt, k);
            check($sformatf("sat%0d.sat_flush_cnt", k), flush_cnt_s, (k < 3) ? k : 3);
            check($sformatf("sat%0d.dv_ev", k), {d_valid, e_valid}, 0);
        end

        // Load r4 then a B-use of r4; reset lands in the stall cycle.
        drive(1, 0, 0, 4, 0, 0, 1, 1, 0);
        @(negedge CLK);
        drive(1, 0, 4, 9, 0, 1, 1, 0, 0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_stall.pre_stall", stall, 1);
        check("rst_stall.pre_flush_cnt", flush_cnt, 5);
        RST_N = 1'b0;
        #1;
        check_idle("rst_stall");
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1, 1, 2, 3, 1, 1, 1, 0, 0);
        @(negedge CLK);
        check("post_rst.d_valid", d_valid, 1);
        check("post_rst.e_valid", e_valid, 0);
        check("post_rst.w_valid", w_valid, 0);
        check("post_rst.stall_cnt", stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brisc_pipe_ctrl.md
BRISC_PIPE_CTRL -- requirements
Module: brisc_pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall/flush counter width.
REQ-003 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port if_valid  in  1  fetch stage presents a decoded instruction.
REQ-006 SHALL have ports if_a_addr, if_b_addr, if_c_addr  in  REG_AW each  source A, source B and destination addresses.
REQ-007 SHALL have ports if_use_a, if_use_b, if_reg_write, if_data_read  in  1 each  source-used, writes-register and is-load flags.
REQ-008 SHALL have port jump_en  in  1  taken jump resolved in execute this cycle.
REQ-009 SHALL have port stall  out  1  hold PC and the fetch/decode register.
REQ-010 SHALL have port flush  out  1  discard the instruction entering decode.
REQ-011 SHALL have ports fwd_a, fwd_b  out  2 each  forwarding select: 0 = register file, 1 = execute result, 2 = writeback result.
REQ-012 SHALL have ports d_valid, e_valid, w_valid  out  1 each  stage-occupied flags.
REQ-013 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  event counters.

Function
REQ-014 SHALL keep one shadow record per stage (D, E, W): valid, c_addr, reg_write, data_read; D also holds a_addr, b_addr, use_a, use_b.
REQ-015 SHALL assert stall combinationally when d_valid, e_valid, E.data_read and E.reg_write are all set and (D.use_a and D.a_addr == E.c_addr, or D.use_b and D.b_addr == E.c_addr).
REQ-016 SHALL assert flush combinationally when jump_en and e_valid are both set; flush SHALL override stall, and stall SHALL read 0 while flush is 1.
REQ-017 On a normal edge SHALL advance E->W, D->E and fetch->D; D.valid takes if_valid.
REQ-018 On a stall edge SHALL advance E->W, hold D unchanged and load a bubble into E (e_valid 0).
REQ-019 On a flush edge SHALL advance E->W, clear e_valid and clear d_valid; fetch inputs are ignored.
REQ-020 SHALL set fwd_a = 1 when E valid, E.reg_write set, E not a load and E.c_addr == D.a_addr; otherwise 2 when W valid, W.reg_write set and W.c_addr == D.a_addr; otherwise 0.
REQ-021 SHALL compute fwd_b identically to fwd_a using D.b_addr.
REQ-022 SHALL drive fwd_a/fwd_b to 0 when the corresponding use flag is 0 or d_valid is 0.
REQ-023 SHALL give E priority over W in forwarding when both match.
REQ-024 SHALL increment stall_cnt on each stall edge and flush_cnt on each flush edge.
REQ-025 SHALL saturate both counters at all-ones and never wrap.
REQ-026 Forwarding and stall/flush outputs SHALL be purely combinational from the current stage state; the one-cycle load-use penalty is the only added latency.
REQ-027 SHALL treat invalid stages as non-matching, with no hazard against a bubble.

Reset
REQ-028 While RST_N = 0, SHALL clear all valid flags, clear both counters and drive stall = 0, flush = 0, fwd_a = fwd_b = 0.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abort the event immediately, with no counter update.
REQ-030 After deassertion, the first edge SHALL load fetch->D only.

Structure
REQ-031 The forwarding-select encodings (REG, EX, WB) and the stage-record field layout SHALL live in the shared BRISC package.
REQ-032 The per-source comparison SHALL be one sub-module, brisc_fwd_sel, instantiated twice (A, B).

Verification
REQ-033 Back-to-back ADD r1 then ADD r2 = r1 + r3 -> fwd_a = 1 in the second instruction's decode cycle; no stall.
REQ-034 Load r4, then an instruction using r4 as B -> stall = 1 for exactly one cycle, E bubble, then fwd_b = 2, stall_cnt = 1.
REQ-035 jump_en with e_valid while a load-use hazard is also present -> flush = 1, stall = 0, d_valid/e_valid = 0 next cycle, flush_cnt = 1, stall_cnt unchanged.
REQ-036 r5 written by both E and W, D reads r5 -> fwd_a = 1 (E priority).
REQ-037 CNT_W = 2 with 5 consecutive flushes -> flush_cnt holds at 3.
REQ-038 RST_N low during a stall cycle -> all outputs 0 immediately, counters 0.
